// File: rtl/code_programmer.sv
// code_programmer: programs a new lock code by entering it once, confirming it, then committing.
// Optional inactivity timeout is enabled by defining CODE_PROG_TIMEOUT_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | no session; code holds the committed value
// S_ENTER   | collecting the first entry into shadow
// S_CONFIRM | collecting the confirm entry, comparing digit by digit
// S_COMMIT  | one cycle: shadow copied into code, done pulsed
module code_programmer #(
  parameter int CODE_LENGTH = 3,
  parameter int DIGIT_WIDTH = 4,
`ifdef CODE_PROG_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 499_999_999,
`endif
  parameter logic [CODE_LENGTH*DIGIT_WIDTH-1:0] DEFAULT_CODE = 12'h123
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 program_req,
  input  logic                                 digit_tick,
  input  logic [DIGIT_WIDTH-1:0]               digit_in,
  input  logic                                 abort,
  output logic [CODE_LENGTH*DIGIT_WIDTH-1:0]   code,
  output logic                                 busy,
  output logic                                 confirm_phase,
  output logic [$clog2(CODE_LENGTH+1)-1:0]     digit_index,
  output logic [DIGIT_WIDTH-1:0]               last_digit,
  output logic                                 done,
  output logic                                 mismatch,
`ifdef CODE_PROG_TIMEOUT_EN
  output logic                                 timeout,
`endif
  output logic                                 reject
);

  localparam int CW   = CODE_LENGTH * DIGIT_WIDTH;
  localparam int IDXW = $clog2(CODE_LENGTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_CONFIRM, S_COMMIT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          shadow_q, shadow_d;
  logic [CW-1:0]          code_q, code_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [DIGIT_WIDTH-1:0] last_q, last_d;
  logic                   match_q, match_d;
  logic                   done_q, done_d;
  logic                   mismatch_q, mismatch_d;
  logic                   reject_q, reject_d;
  logic                   digit_valid;
  logic                   last_pos;
  logic [DIGIT_WIDTH-1:0] exp_digit;

`ifdef CODE_PROG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    code_d      = code_q;
    idx_d       = idx_q;
    last_d      = last_q;
    match_d     = match_q;
    done_d      = 1'b0;
    mismatch_d  = 1'b0;
    reject_d    = 1'b0;
    digit_valid = (digit_in <= DIGIT_WIDTH'(9));
    last_pos    = (idx_q == IDXW'(CODE_LENGTH - 1));
    exp_digit   = '0;
`ifdef CODE_PROG_TIMEOUT_EN
    to_d      = to_q;
    timeout_d = 1'b0;
`endif
    // First entered digit lives in the MS nibble, so position i sits at nibble CODE_LENGTH-1-i.
    for (int i = 0; i < CODE_LENGTH; i++) begin
      if (idx_q == IDXW'(i)) exp_digit = shadow_q[(CODE_LENGTH-1-i)*DIGIT_WIDTH +: DIGIT_WIDTH];
    end

    case (state_q)
      S_IDLE: begin
        if (program_req) begin
          state_d  = S_ENTER;
          idx_d    = '0;
          shadow_d = '0;
`ifdef CODE_PROG_TIMEOUT_EN
          to_d = TW'(TIMEOUT_CYCLES);
`endif
        end
      end
      S_ENTER, S_CONFIRM: begin
        if (abort) begin
          state_d  = S_IDLE;
          idx_d    = '0;
          shadow_d = '0;
        end else if (digit_tick) begin
`ifdef CODE_PROG_TIMEOUT_EN
          to_d = TW'(TIMEOUT_CYCLES);
`endif
          if (!digit_valid) begin
            reject_d = 1'b1;
          end else begin
            last_d = digit_in;
            if (state_q == S_ENTER) begin
              shadow_d = {shadow_q[CW-DIGIT_WIDTH-1:0], digit_in};
              if (last_pos) begin
                state_d = S_CONFIRM;
                idx_d   = '0;
                match_d = 1'b1;
              end else begin
                idx_d = idx_q + IDXW'(1);
              end
            end else if (last_pos) begin
              idx_d = '0;
              if (match_q && (digit_in == exp_digit)) begin
                state_d = S_COMMIT;
              end else begin
                state_d    = S_ENTER;
                mismatch_d = 1'b1;
                shadow_d   = '0;
              end
            end else begin
              idx_d = idx_q + IDXW'(1);
              if (digit_in != exp_digit) match_d = 1'b0;
            end
          end
        end
`ifdef CODE_PROG_TIMEOUT_EN
        else if (to_q == '0) begin
          state_d   = S_IDLE;
          idx_d     = '0;
          shadow_d  = '0;
          timeout_d = 1'b1;
        end else begin
          to_d = to_q - TW'(1);
        end
`endif
      end
      S_COMMIT: begin
        code_d  = shadow_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      code_q     <= DEFAULT_CODE;
      idx_q      <= '0;
      last_q     <= '0;
      match_q    <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      reject_q   <= 1'b0;
`ifdef CODE_PROG_TIMEOUT_EN
      to_q      <= TW'(TIMEOUT_CYCLES);
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      code_q     <= code_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      match_q    <= match_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      reject_q   <= reject_d;
`ifdef CODE_PROG_TIMEOUT_EN
      to_q      <= to_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign code          = code_q;
  assign busy          = (state_q != S_IDLE);
  assign confirm_phase = (state_q == S_CONFIRM);
  assign digit_index   = idx_q;
  assign last_digit    = last_q;
  assign done          = done_q;
  assign mismatch      = mismatch_q;
  assign reject        = reject_q;
`ifdef CODE_PROG_TIMEOUT_EN
  assign timeout       = timeout_q;
`endif

endmodule

// File: tb/tb_code_programmer.sv
// Bench for code_programmer: directed sessions with a pulse-event scoreboard (done/mismatch/reject).
module tb_code_programmer;

  logic        clk;
  logic        reset;
  logic        program_req;
  logic        digit_tick;
  logic [3:0]  digit_in;
  logic        abort;
  logic [11:0] code;
  logic        busy;
  logic        confirm_phase;
  logic [1:0]  digit_index;
  logic [3:0]  last_digit;
  logic        done;
  logic        mismatch;
  logic        reject;

  int n_cmp = 0;
  int n_err = 0;
  logic [13:0] sb_q[$];
  logic [11:0] exp_code;

  localparam logic [1:0] EV_DONE = 2'd1, EV_MISM = 2'd2, EV_REJ = 2'd3;

  code_programmer dut (
    .clk(clk), .reset(reset), .program_req(program_req), .digit_tick(digit_tick),
    .digit_in(digit_in), .abort(abort), .code(code), .busy(busy),
    .confirm_phase(confirm_phase), .digit_index(digit_index), .last_digit(last_digit),
    .done(done), .mismatch(mismatch), .reject(reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic pr, input logic tk, input logic ab, input logic [3:0] d);
    program_req = pr;
    digit_tick  = tk;
    abort       = ab;
    digit_in    = d;
    @(negedge clk);
    program_req = 1'b0;
    digit_tick  = 1'b0;
    abort       = 1'b0;
  endtask

  task automatic tick(input logic [3:0] d);
    drive(1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic push_evt(input logic [1:0] kind, input logic [11:0] c);
    sb_q.push_back({kind, c});
  endtask

  task automatic expect_state(input logic b, input logic cp, input logic [1:0] idx);
    check_eq("busy", 32'(busy), 32'(b));
    check_eq("confirm_phase", 32'(confirm_phase), 32'(cp));
    check_eq("digit_index", 32'(digit_index), 32'(idx));
  endtask

  // Every pulse must match the oldest expected event, including the code visible at that moment.
  always @(negedge clk) begin
    logic [13:0] evt;
    logic [13:0] exp_evt;
    if (!reset && (done || mismatch || reject)) begin
      check_eq("pulse_onehot", 32'($countones({done, mismatch, reject})), 32'd1);
      evt = {(done ? EV_DONE : (mismatch ? EV_MISM : EV_REJ)), code};
      if (sb_q.size() == 0) begin
        check_eq("unexpected_evt", 32'(evt), 32'd0);
      end else begin
        exp_evt = sb_q.pop_front();
        check_eq("evt", 32'(evt), 32'(exp_evt));
      end
    end
  end

  initial begin
    reset = 1'b1; program_req = 1'b0; digit_tick = 1'b0; abort = 1'b0; digit_in = 4'd0;
    exp_code = 12'h123;
    repeat (3) step();
    reset = 1'b0;
    step();

    check_eq("reset_code", 32'(code), 32'(exp_code));
    expect_state(1'b0, 1'b0, 2'd0);
    check_eq("reset_last", 32'(last_digit), 32'd0);
    check_eq("reset_pulses", 32'({done, mismatch, reject}), 32'd0);

    for (int i = 0; i < 5; i++) begin
      tick((i == 2) ? 4'hC : 4'(i + 3));
      expect_state(1'b0, 1'b0, 2'd0);
      check_eq("idle_last", 32'(last_digit), 32'd0);
    end

    // Successful program of 456.
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    expect_state(1'b1, 1'b0, 2'd0);
    tick(4'd4); expect_state(1'b1, 1'b0, 2'd1); check_eq("last", 32'(last_digit), 32'd4);
    tick(4'd5); expect_state(1'b1, 1'b0, 2'd2); check_eq("last", 32'(last_digit), 32'd5);
    tick(4'd6); expect_state(1'b1, 1'b1, 2'd0); check_eq("last", 32'(last_digit), 32'd6);
    tick(4'd4); expect_state(1'b1, 1'b1, 2'd1);
    tick(4'd5); expect_state(1'b1, 1'b1, 2'd2);
    push_evt(EV_DONE, 12'h456);
    tick(4'd6);
    expect_state(1'b1, 1'b0, 2'd0);
    check_eq("code_hold_commit", 32'(code), 32'(exp_code));
    step();
    exp_code = 12'h456;
    check_eq("code_commit", 32'(code), 32'(exp_code));
    check_eq("done_pulse", 32'(done), 32'd1);
    expect_state(1'b0, 1'b0, 2'd0);
    step();
    check_eq("done_once", 32'(done), 32'd0);

    // Confirm mismatch returns to ENTER.
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    tick(4'd7); tick(4'd8); tick(4'd9);
    tick(4'd7); tick(4'd0);
    push_evt(EV_MISM, exp_code);
    tick(4'd9);
    check_eq("mismatch_pulse", 32'(mismatch), 32'd1);
    expect_state(1'b1, 1'b0, 2'd0);
    check_eq("code_after_mism", 32'(code), 32'(exp_code));

    // Rejected digit leaves index/echo alone; program_req while busy ignored.
    tick(4'd1); expect_state(1'b1, 1'b0, 2'd1); check_eq("last", 32'(last_digit), 32'd1);
    push_evt(EV_REJ, exp_code);
    tick(4'hC);
    check_eq("reject_pulse", 32'(reject), 32'd1);
    expect_state(1'b1, 1'b0, 2'd1); check_eq("last_after_rej", 32'(last_digit), 32'd1);
    tick(4'd2); expect_state(1'b1, 1'b0, 2'd2); check_eq("last", 32'(last_digit), 32'd2);
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    expect_state(1'b1, 1'b0, 2'd2);
    tick(4'd3); expect_state(1'b1, 1'b1, 2'd0);
    tick(4'd1); tick(4'd2);
    expect_state(1'b1, 1'b1, 2'd2);
    // Abort wins over a tick that would otherwise complete a matching confirm.
    drive(1'b0, 1'b1, 1'b1, 4'd3);
    expect_state(1'b0, 1'b0, 2'd0);
    check_eq("code_after_abort", 32'(code), 32'(exp_code));
    repeat (3) step();
    check_eq("code_after_abort2", 32'(code), 32'(exp_code));
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    expect_state(1'b0, 1'b0, 2'd0);

    // Reset in the middle of ENTER.
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    tick(4'd8);
    expect_state(1'b1, 1'b0, 2'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_code = 12'h123;
    check_eq("code_after_reset", 32'(code), 32'(exp_code));
    expect_state(1'b0, 1'b0, 2'd0);
    check_eq("last_after_reset", 32'(last_digit), 32'd0);

    // Boundary digits 0/9, reject of 10 in CONFIRM, abort+tick during COMMIT ignored.
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    tick(4'd0); tick(4'd0); tick(4'd9);
    expect_state(1'b1, 1'b1, 2'd0);
    tick(4'd0);
    push_evt(EV_REJ, exp_code);
    tick(4'hA);
    expect_state(1'b1, 1'b1, 2'd1);
    tick(4'd0);
    push_evt(EV_DONE, 12'h009);
    tick(4'd9);
    expect_state(1'b1, 1'b0, 2'd0);
    drive(1'b0, 1'b1, 1'b1, 4'd5);
    exp_code = 12'h009;
    check_eq("code_commit2", 32'(code), 32'(exp_code));
    expect_state(1'b0, 1'b0, 2'd0);
    repeat (2) step();
    check_eq("code_hold_idle", 32'(code), 32'(exp_code));

    repeat (2) step();
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
